maq_h: RTL

- Hour stage of the digital clock (relógio), directly downstream of the minute stage.
- Consumes the minute stage's level carry (high while minutes read 59) and counts hours 00–23 as two BCD digits.
- Emits a one-cycle day-carry pulse on 23→00 rollover.
- Provides a manual hour-set mode driven by a debounced button pulse.

---
 rtl/maq_h_if.sv | 20 ++
 rtl/maq_h.sv | 120 ++++++++++++
 2 files changed

// File: rtl/maq_h_if.sv
// rtl/maq_h_if.sv - carry/set-mode inputs and BCD hour display bundle for maq_h
interface maq_h_if;
  logic       inc_hora;
  logic       maqh_ajuste;
  logic       maqh_botao;
  logic [3:0] maqh_lsd;
  logic [1:0] maqh_msd;
  logic       maqh_inc_dia;
  logic       maqh_pm;

  modport master (
    output inc_hora, maqh_ajuste, maqh_botao,
    input  maqh_lsd, maqh_msd, maqh_inc_dia, maqh_pm
  );

  modport slave (
    input  inc_hora, maqh_ajuste, maqh_botao,
    output maqh_lsd, maqh_msd, maqh_inc_dia, maqh_pm
  );
endinterface

// File: rtl/maq_h.sv
// rtl/maq_h.sv - hour stage 00-23 BCD counter with set mode, day carry; FORMATO_12H_EN selects 12 h display
module maq_h #(
  parameter int HORA_INICIAL = 0
) (
  input logic    maqh_clock,
  input logic    maqh_reset,
  maq_h_if.slave bus
);

  localparam logic [3:0] LSD_INI = 4'(HORA_INICIAL % 10);
  localparam logic [1:0] MSD_INI = 2'(HORA_INICIAL / 10);

  typedef enum logic {CONTA, AJUSTE} state_t;

  state_t     state, state_nx;
  logic [3:0] lsd, lsd_nx;
  logic [1:0] msd, msd_nx;
  logic       inc_q;
  logic       inc_dia, inc_dia_nx;
  logic       advance;
  logic       step;
  logic       wrap;
  logic [3:0] disp_lsd;
  logic [1:0] disp_msd;
  logic       disp_pm;

  // State, digit and carry-edge registers; reset dominates everything
  always_ff @(posedge maqh_clock) begin
    if (!maqh_reset) begin
      state   <= CONTA;
      lsd     <= LSD_INI;
      msd     <= MSD_INI;
      inc_q   <= 1'b0;
      inc_dia <= 1'b0;
    end else begin
      state   <= state_nx;
      lsd     <= lsd_nx;
      msd     <= msd_nx;
      inc_q   <= bus.inc_hora;
      inc_dia <= inc_dia_nx;
    end
  end

  // Mode selection, step source (carry edge in CONTA, button in AJUSTE) and digit advance
  always_comb begin
    state_nx   = state;
    lsd_nx     = lsd;
    msd_nx     = msd;
    inc_dia_nx = 1'b0;
    advance    = inc_q & ~bus.inc_hora;
    wrap       = (msd == 2'd2) && (lsd == 4'd3);
    step       = 1'b0;

    case (state)
      CONTA: begin
        step = advance;
        if (bus.maqh_ajuste) state_nx = AJUSTE;
      end
      AJUSTE: begin
        step = bus.maqh_botao;
        if (!bus.maqh_ajuste) state_nx = CONTA;
      end
      default: state_nx = CONTA;
    endcase

    if (step) begin
      if (wrap) begin
        lsd_nx = 4'd0;
        msd_nx = 2'd0;
        // Only a carry-driven midnight advances the day; manual setting does not.
        inc_dia_nx = (state == CONTA);
      end else if (lsd == 4'd9) begin
        lsd_nx = 4'd0;
        msd_nx = msd + 2'd1;
      end else begin
        lsd_nx = lsd + 4'd1;
      end
    end
  end

`ifdef FORMATO_12H_EN
  logic [4:0] hour24;
  logic [4:0] hour12;

  // 12 h display decode of the 24 h internal count
  always_comb begin
    hour24 = 5'(msd) * 5'd10 + 5'(lsd);
    hour12 = hour24;
    disp_pm = 1'b0;
    if (hour24 == 5'd0) begin
      hour12 = 5'd12;
    end else if (hour24 == 5'd12) begin
      disp_pm = 1'b1;
    end else if (hour24 > 5'd12) begin
      hour12  = hour24 - 5'd12;
      disp_pm = 1'b1;
    end
    if (hour12 >= 5'd10) begin
      disp_msd = 2'd1;
      disp_lsd = 4'(hour12 - 5'd10);
    end else begin
      disp_msd = 2'd0;
      disp_lsd = 4'(hour12);
    end
  end
`else
  // 24 h display is the raw count
  always_comb begin
    disp_lsd = lsd;
    disp_msd = msd;
    disp_pm  = 1'b0;
  end
`endif

  assign bus.maqh_lsd     = disp_lsd;
  assign bus.maqh_msd     = disp_msd;
  assign bus.maqh_pm      = disp_pm;
  assign bus.maqh_inc_dia = inc_dia;

endmodule
